// File: rtl/btb_assoc_array_if.sv
`default_nettype none
// ============================================================================
//  Module   : btb_assoc_array_if
//  Brief    : Lookup, update and flush signal bundle for btb_assoc_array.
//  Revision : 1.0 - initial release
// ============================================================================
interface btb_assoc_array_if #(
    parameter int S_INDEX  = 4,
    parameter int S_TAG    = 8,
    parameter int WIDTH    = 32,
    parameter int NUM_WAYS = 2
);
    localparam int c_WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic               rd_en;
    logic [S_INDEX-1:0] rindex;
    logic [S_TAG-1:0]   rtag;
    logic               hit;
    logic [WIDTH-1:0]   target;
    logic [c_WAY_W-1:0] hit_way;
    logic               load;
    logic [S_INDEX-1:0] windex;
    logic [S_TAG-1:0]   wtag;
    logic [WIDTH-1:0]   datain;
    logic               flush;
    logic               busy;

    modport master (
        output rd_en, rindex, rtag, load, windex, wtag, datain, flush,
        input  hit, target, hit_way, busy
    );

    modport slave (
        input  rd_en, rindex, rtag, load, windex, wtag, datain, flush,
        output hit, target, hit_way, busy
    );
endinterface
`default_nettype wire

// File: rtl/btb_assoc_array.sv
`default_nettype none
// ============================================================================
//  Module   : btb_assoc_array
//  Brief    : N-way set-associative BTB storage, tree PLRU, write forwarding
//             and a one-set-per-cycle flush sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module btb_assoc_array #(
    parameter int S_INDEX  = 4,
    parameter int S_TAG    = 8,
    parameter int WIDTH    = 32,
    parameter int NUM_WAYS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    btb_assoc_array_if.slave    bus
);
    localparam int c_NUM_SETS = 2 ** S_INDEX;
    localparam int c_LVL      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;
    localparam int c_WAY_W    = (NUM_WAYS > 1) ? c_LVL : 1;
    localparam int c_PLRU_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [S_INDEX-1:0] r_cnt, w_cnt_nxt;

    logic [NUM_WAYS-1:0] r_valid [c_NUM_SETS];
    logic [c_PLRU_W-1:0] r_plru  [c_NUM_SETS];
    logic [S_TAG-1:0]    r_tag   [c_NUM_SETS][NUM_WAYS];
    logic [WIDTH-1:0]    r_tgt   [c_NUM_SETS][NUM_WAYS];

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    function automatic logic [c_PLRU_W-1:0] f_touch(input logic [c_PLRU_W-1:0] p,
                                                    input logic [c_WAY_W-1:0]  way);
        logic [c_PLRU_W-1:0] r;
        logic [c_PLRU_W-1:0] m;
        int n;
        int d;
        r = p;
        n = 0;
        for (int l = 0; l < c_LVL; l++) begin
            d = (int'(way) >> (c_LVL - 1 - l)) & 1;
            m = c_PLRU_W'(1) << n;
            r = (d != 0) ? (r & ~m) : (r | m);
            n = 2 * n + 1 + d;
        end
        return r;
    endfunction

    function automatic logic [c_WAY_W-1:0] f_victim(input logic [c_PLRU_W-1:0] p);
        logic [c_PLRU_W-1:0] s;
        int n;
        n = 0;
        for (int l = 0; l < c_LVL; l++) begin
            s = p >> n;
            n = 2 * n + 1 + (s[0] ? 1 : 0);
        end
        return c_WAY_W'(n - (NUM_WAYS - 1));
    endfunction

    logic                w_idle;
    logic                w_load_acc;
    logic                w_arr_hit;
    logic [c_WAY_W-1:0]  w_arr_way;
    logic                w_wm_hit;
    logic [c_WAY_W-1:0]  w_wm_way;
    logic                w_inv_any;
    logic [c_WAY_W-1:0]  w_inv_way;
    logic                w_rd_touch;
    logic [c_PLRU_W-1:0] w_plru_rd;
    logic [c_PLRU_W-1:0] w_plru_wbase;
    logic [c_PLRU_W-1:0] w_plru_wr;
    logic [c_WAY_W-1:0]  w_wway;
    logic                w_fwd;

    always_comb begin
        w_idle     = (r_state == S_IDLE);
        w_load_acc = w_idle && bus.load && !bus.flush;

        w_arr_hit = 1'b0;
        w_arr_way = '0;
        w_wm_hit  = 1'b0;
        w_wm_way  = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[bus.rindex][w] && (r_tag[bus.rindex][w] == bus.rtag)) begin
                w_arr_hit = 1'b1;
                w_arr_way = c_WAY_W'(w);
            end
            if (r_valid[bus.windex][w] && (r_tag[bus.windex][w] == bus.wtag)) begin
                w_wm_hit = 1'b1;
                w_wm_way = c_WAY_W'(w);
            end
        end
        // Descending scan so the lowest-numbered invalid way is kept.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[bus.windex][w]) begin
                w_inv_any = 1'b1;
                w_inv_way = c_WAY_W'(w);
            end
        end

        // A same-set lookup touch is applied before the write picks and touches.
        w_rd_touch   = w_idle && bus.rd_en && w_arr_hit;
        w_plru_rd    = f_touch(r_plru[bus.rindex], w_arr_way);
        w_plru_wbase = (w_rd_touch && (bus.rindex == bus.windex)) ? w_plru_rd
                                                                  : r_plru[bus.windex];
        w_wway       = w_wm_hit  ? w_wm_way  :
                       w_inv_any ? w_inv_way : f_victim(w_plru_wbase);
        w_plru_wr    = f_touch(w_plru_wbase, w_wway);

        w_fwd = w_load_acc && (bus.windex == bus.rindex) && (bus.wtag == bus.rtag);

        bus.hit     = w_idle && (w_fwd || w_arr_hit);
        bus.target  = '0;
        bus.hit_way = '0;
        if (w_fwd) begin
            bus.target  = bus.datain;
            bus.hit_way = w_wway;
        end else if (bus.hit) begin
            bus.target  = r_tgt[bus.rindex][w_arr_way];
            bus.hit_way = w_arr_way;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        bus.busy    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.flush) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                bus.busy  = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (&r_cnt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < c_NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else if (r_state == S_FLUSH) begin
            r_valid[r_cnt] <= '0;
            r_plru[r_cnt]  <= '0;
        end else begin
            if (w_rd_touch) begin
                r_plru[bus.rindex] <= w_plru_rd;
            end
            if (w_load_acc) begin
                r_valid[bus.windex][w_wway] <= 1'b1;
                r_plru[bus.windex]          <= w_plru_wr;
            end
        end
    end

    // Tag/target payload is unreset; valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            r_tag[bus.windex][w_wway] <= bus.wtag;
            r_tgt[bus.windex][w_wway] <= bus.datain;
        end
    end
endmodule
`default_nettype wire
